// File: rtl/clock_divider_n.sv
// Programmable integer clock divider (N = 2..2^DIV_W-1) with tick strobe and boundary-synchronised divisor update.
// Optional: define CLKDIV_ODD_DUTY50_EN for exact 50% duty on odd N (adds a negedge flop).
module clock_divider_n #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             load_ack,
  output logic             cfg_err
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] active_n_reg;
  logic [DIV_W-1:0] pending_n_reg;
  logic             pending_valid_reg;
  logic             clk_out_reg;
  logic             tick_reg;
  logic             load_ack_reg;
  logic             cfg_err_reg;

  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] half_n;
  logic             boundary;
  logic             load_ok;
  logic             apply;

  always_comb begin
    cnt_next = (cnt_reg == active_n_reg - ONE) ? '0 : cnt_reg + ONE;
    boundary = (cnt_next == '0);
    half_n   = active_n_reg >> 1;
    load_ok  = load && (div_val >= TWO);
    // pending_valid_reg only reflects loads from earlier edges, so a load on this boundary waits
    apply    = en && boundary && pending_valid_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg           <= DEF_N - ONE;
      active_n_reg      <= DEF_N;
      pending_n_reg     <= DEF_N;
      pending_valid_reg <= 1'b0;
      clk_out_reg       <= 1'b0;
      tick_reg          <= 1'b0;
      load_ack_reg      <= 1'b0;
      cfg_err_reg       <= 1'b0;
    end else begin
      cfg_err_reg  <= load && (div_val < TWO);
      load_ack_reg <= apply;
      tick_reg     <= en && boundary;
      if (en) begin
        cnt_reg     <= cnt_next;
        // at a boundary cnt_next is 0, which is below any H>=1, so old/new H agree here
        clk_out_reg <= (cnt_next < half_n);
      end
      if (apply) begin
        active_n_reg      <= pending_n_reg;
        pending_valid_reg <= 1'b0;
      end
      if (load_ok) begin
        pending_n_reg     <= div_val;
        pending_valid_reg <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic neg_reg;

  // Half-cycle delayed copy of the high phase stretches it by 0.5 clk for odd N
  always_ff @(negedge clk) begin
    if (!reset) begin
      neg_reg <= 1'b0;
    end else begin
      neg_reg <= active_n_reg[0] & clk_out_reg;
    end
  end

  assign clk_out = clk_out_reg | neg_reg;
`else
  assign clk_out = clk_out_reg;
`endif

  assign tick     = tick_reg;
  assign load_ack = load_ack_reg;
  assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_clock_divider_n.sv
// Bench for clock_divider_n: fixed vector table, directed multi-cycle sequences and random
// stimulus, all checked against a queue-based waveform model of the divider.
module tb_clock_divider_n;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             clk_out;
  logic             tick;
  logic             load_ack;
  logic             cfg_err;

  clock_divider_n #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .load_ack(load_ack),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each output period is a queue of {clk_out, tick} samples, refilled when it runs dry.
  int       m_n      = DEFAULT_DIV;
  int       m_pend_n = 0;
  bit       m_pend_v = 1'b0;
  bit [1:0] m_q[$];
  bit       m_clk    = 1'b0;
  bit       m_tick   = 1'b0;
  bit       m_ack    = 1'b0;
  bit       m_err    = 1'b0;

  typedef struct {
    bit r;
    bit e;
    bit l;
    int dv;
    bit c;
    bit t;
    bit a;
    bit er;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input int dv);
    if (!r) begin
      m_n      = DEFAULT_DIV;
      m_pend_v = 1'b0;
      m_q.delete();
      m_clk    = 1'b0;
      m_tick   = 1'b0;
      m_ack    = 1'b0;
      m_err    = 1'b0;
      return;
    end
    m_err  = l && (dv < 2);
    m_ack  = 1'b0;
    m_tick = 1'b0;
    if (e) begin
      if (m_q.size() == 0) begin
        if (m_pend_v) begin
          m_n      = m_pend_n;
          m_pend_v = 1'b0;
          m_ack    = 1'b1;
        end
        for (int i = 0; i < m_n; i++)
          m_q.push_back({bit'(i < m_n / 2), bit'(i == 0)});
      end
      {m_clk, m_tick} = m_q.pop_front();
    end
    if (l && dv >= 2) begin
      m_pend_n = dv;
      m_pend_v = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int dv);
    @(negedge clk);
    reset   = r;
    en      = e;
    load    = l;
    div_val = DIV_W'(dv);
    @(posedge clk);
    model_edge(r, e, l, dv);
    #1;
    chk("clk_out", clk_out, m_clk);
    chk("tick", tick, m_tick);
    chk("load_ack", load_ack, m_ack);
    chk("cfg_err", cfg_err, m_err);
  endtask

  initial begin
    int acks;
    int highs;
    int ticks;
    bit seen;

    // reset, release at N=2, rejected loads, then load 5
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 1, 1, 0, 1};
    tbl[8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    tbl[9]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{1, 1, 1, 5, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 1, 1, 1, 0};
    tbl[12] = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 1, 1, 0, 0};
    tbl[17] = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[18] = '{1, 1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].dv);
      chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].c);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].t);
      chk($sformatf("tbl%0d_ack", i), load_ack, tbl[i].a);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].er);
      $display("vec %0d: clk_out=%0b tick=%0b load_ack=%0b cfg_err=%0b", i, clk_out, tick, load_ack, cfg_err);
    end

    // load captured on the first (boundary) edge waits for the next boundary
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 8);
    chk("boundary_load_ack_early", load_ack, 1'b0);
    step(1, 1, 0, 0);
    chk("boundary_load_ack_mid", load_ack, 1'b0);
    step(1, 1, 0, 0);
    chk("boundary_load_ack_next", load_ack, 1'b1);
    $display("seq boundary-load: load_ack=%0b", load_ack);

    // two loads before the boundary: only the last (4) applies, with one ack
    step(1, 1, 1, 6);
    step(1, 1, 0, 0);
    step(1, 1, 1, 4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, 0);
      seen = load_ack;
    end
    chk("overwrite_ack_seen", seen, 1'b1);
    highs = int'(clk_out);
    ticks = int'(tick);
    acks  = 0;
    for (int k = 0; k < 7; k++) begin
      step(1, 1, 0, 0);
      highs += int'(clk_out);
      ticks += int'(tick);
      acks  += int'(load_ack);
    end
    chk_int("overwrite_highs", highs, 4);
    chk_int("overwrite_ticks", ticks, 2);
    chk_int("overwrite_extra_acks", acks, 0);
    $display("seq overwrite: highs=%0d ticks=%0d extra_acks=%0d", highs, ticks, acks);

    // N=8, freeze for 5 cycles in the high phase; total enabled high time stays 4
    step(1, 1, 1, 8);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, 0);
      seen = load_ack;
    end
    chk("freeze_ack_seen", seen, 1'b1);
    highs = int'(clk_out);
    step(1, 1, 0, 0);
    highs += int'(clk_out);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0);
      chk("freeze_clk_hold", clk_out, 1'b1);
      chk("freeze_tick_low", tick, 1'b0);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, 0);
      seen = tick;
      if (!seen) highs += int'(clk_out);
    end
    chk("freeze_tick_seen", seen, 1'b1);
    chk_int("freeze_high_total", highs, 4);
    $display("seq freeze: high_total=%0d", highs);

    // random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      step(bit'($urandom_range(99) != 0), bit'($urandom_range(9) < 8),
           bit'($urandom_range(9) == 0), int'($urandom_range(11)));
    end
    $display("random: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
